mpu_axis_monitor: RTL and testbench

- Parametrised successor to the single-axis XREG capture and sign compare in the MPU6050 demo path.
- Generates the I2C pacing tick (TIC).
- Captures up to NUM_AXES big-endian 16-bit register pairs streamed by the MPU6050 sequencer (ADR/DATA/LOAD) and commits them atomically at frame end.
- Derives per-axis sign, hysteretic tilt flags and a shake event for the Tamagotchi logic, then re-arms the sequencer via RESCAN.

---
 rtl/mpu_pkg.sv | 20 ++
 rtl/tic_gen.sv | 24 ++
 rtl/mpu_axis_monitor.sv | 198 +++++++++++++++++++
 tb/tb_mpu_axis_monitor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU6050 axis monitor: register map, sample width and FSM encoding.
package mpu_pkg;

    localparam int unsigned SAMPLE_W = 16;

    localparam logic [3:0] ACC_X_H = 4'd0;
    localparam logic [3:0] ACC_X_L = 4'd1;
    localparam logic [3:0] ACC_Y_H = 4'd2;
    localparam logic [3:0] ACC_Y_L = 4'd3;
    localparam logic [3:0] ACC_Z_H = 4'd4;
    localparam logic [3:0] ACC_Z_L = 4'd5;

    typedef enum logic [1:0] {
        StCollect,
        StCommit,
        StEval,
        StRescan
    } mon_state_e;

endpackage

// File: rtl/tic_gen.sv
// Free-running divider producing a one-cycle TIC every TIC_DIV clocks; paces the I2C blocks.
module tic_gen #(
    parameter int unsigned TIC_DIV = 160
) (
    input  logic MCLK,
    input  logic nRST,
    output logic TIC
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign TIC   = (cnt_q == 8'(TIC_DIV - 1));
    assign cnt_d = TIC ? 8'd0 : cnt_q + 8'd1;

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mpu_axis_monitor.sv
// Captures streamed MPU6050 register pairs, commits them per frame and derives sign,
// hysteretic tilt flags and a shake event before re-arming the sequencer.
module mpu_axis_monitor
    import mpu_pkg::*;
#(
    parameter int unsigned TIC_DIV   = 160,
    parameter int unsigned NUM_AXES  = 3,
    parameter int          THRESH    = 4000,
    parameter int          HYST      = 500,
    parameter int unsigned SHAKE_CNT = 4,
    parameter int unsigned SHAKE_WIN = 8
) (
    input  logic                         MCLK,
    input  logic                         nRST,
    output logic                         TIC,
    input  logic                         LOAD,
    input  logic [3:0]                   ADR,
    input  logic [7:0]                   DATA,
    input  logic                         COMPLETED,
    output logic                         RESCAN,
    output logic [SAMPLE_W*NUM_AXES-1:0] AXIS_DATA,
    output logic                         SAMPLE_VALID,
    output logic [NUM_AXES-1:0]          SIGN,
    output logic [NUM_AXES-1:0]          TILT_POS,
    output logic [NUM_AXES-1:0]          TILT_NEG,
    output logic                         SHAKE,
    output logic                         FRAME_ERR
);

    localparam int unsigned NUM_BYTES = 2 * NUM_AXES;
    localparam int unsigned AW        = SAMPLE_W * NUM_AXES;

    localparam logic signed [16:0] SET_P = 17'(THRESH);
    localparam logic signed [16:0] SET_N = -SET_P;
    localparam logic signed [16:0] CLR_P = 17'(THRESH - HYST);
    localparam logic signed [16:0] CLR_N = -CLR_P;

    logic tic;

    mon_state_e state_q, state_d;

    logic [NUM_BYTES-1:0][7:0] stage_q, stage_d, stage_wr;
    logic [NUM_BYTES-1:0]      mask_q, mask_d, mask_wr;
    logic [AW-1:0]             axis_q, axis_d, axis_wr;

    logic [NUM_AXES-1:0] sign_q, sign_d;
    logic [NUM_AXES-1:0] pos_q, pos_d, pos_eval;
    logic [NUM_AXES-1:0] neg_q, neg_d, neg_eval;

    logic       valid_q, valid_d;
    logic       shake_q, shake_d;
    logic       ferr_q, ferr_d;
    logic [7:0] frame_q, frame_d, frame_inc;
    logic [7:0] chg_q, chg_d, chg_inc;
    logic       tilt_changed;

    tic_gen #(
        .TIC_DIV(TIC_DIV)
    ) u_tic_gen (
        .MCLK(MCLK),
        .nRST(nRST),
        .TIC (tic)
    );

    // Staging view including a byte that lands on this very TIC, so a LOAD coinciding
    // with COMPLETED is counted before the mask is checked.
    always_comb begin
        stage_wr = stage_q;
        mask_wr  = mask_q;
        if (state_q == StCollect && tic && LOAD) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (ADR == 4'(i)) begin
                    stage_wr[i] = DATA;
                    mask_wr[i]  = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_AXES; i++) begin
            axis_wr[i*SAMPLE_W +: SAMPLE_W] = {stage_wr[2*i], stage_wr[2*i+1]};
        end
    end

    for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
        logic signed [16:0] s;
        assign s = {axis_q[g*SAMPLE_W+SAMPLE_W-1], axis_q[g*SAMPLE_W +: SAMPLE_W]};
        assign pos_eval[g] = (s > SET_P) ? 1'b1 : (s < CLR_P) ? 1'b0 : pos_q[g];
        assign neg_eval[g] = (s < SET_N) ? 1'b1 : (s > CLR_N) ? 1'b0 : neg_q[g];
    end

    assign tilt_changed = |((pos_eval ^ pos_q) | (neg_eval ^ neg_q));
    assign frame_inc    = frame_q + 8'd1;
    assign chg_inc      = chg_q + {7'd0, tilt_changed};

    // Each stage's results are registered on entry: SAMPLE_VALID is high while in COMMIT,
    // the tilt flags and SHAKE are evaluated there and become visible during EVAL.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        mask_d  = mask_q;
        axis_d  = axis_q;
        sign_d  = sign_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        frame_d = frame_q;
        chg_d   = chg_q;
        valid_d = 1'b0;
        shake_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            StCollect: begin
                stage_d = stage_wr;
                mask_d  = mask_wr;
                if (tic && COMPLETED) begin
                    mask_d = '0;
                    if (&mask_wr) begin
                        state_d = StCommit;
                        axis_d  = axis_wr;
                        valid_d = 1'b1;
                        for (int i = 0; i < NUM_AXES; i++) begin
                            sign_d[i] = axis_wr[i*SAMPLE_W+SAMPLE_W-1];
                        end
                    end else begin
                        state_d = StRescan;
                        ferr_d  = 1'b1;
                    end
                end
            end
            StCommit: begin
                pos_d   = pos_eval;
                neg_d   = neg_eval;
                state_d = StEval;
                if (chg_inc == 8'(SHAKE_CNT)) begin
                    shake_d = 1'b1;
                    frame_d = 8'd0;
                    chg_d   = 8'd0;
                end else if (frame_inc == 8'(SHAKE_WIN)) begin
                    frame_d = 8'd0;
                    chg_d   = 8'd0;
                end else begin
                    frame_d = frame_inc;
                    chg_d   = chg_inc;
                end
            end
            StEval: begin
                state_d = StRescan;
            end
            StRescan: begin
                if (tic) begin
                    state_d = StCollect;
                end
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StCollect;
            stage_q <= '0;
            mask_q  <= '0;
            axis_q  <= '0;
            sign_q  <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
            frame_q <= 8'd0;
            chg_q   <= 8'd0;
            valid_q <= 1'b0;
            shake_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            mask_q  <= mask_d;
            axis_q  <= axis_d;
            sign_q  <= sign_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            frame_q <= frame_d;
            chg_q   <= chg_d;
            valid_q <= valid_d;
            shake_q <= shake_d;
            ferr_q  <= ferr_d;
        end
    end

    assign TIC          = tic;
    assign RESCAN       = (state_q == StRescan);
    assign AXIS_DATA    = axis_q;
    assign SAMPLE_VALID = valid_q;
    assign SIGN         = sign_q;
    assign TILT_POS     = pos_q;
    assign TILT_NEG     = neg_q;
    assign SHAKE        = shake_q;
    assign FRAME_ERR    = ferr_q;

endmodule

// File: tb/tb_mpu_axis_monitor.sv
// Directed bench for mpu_axis_monitor: TIC cadence, a table of frames, and reset/ignore corners.
module tb_mpu_axis_monitor;
    import mpu_pkg::*;

    logic        MCLK = 1'b0;
    logic        nRST = 1'b0;
    logic        LOAD = 1'b0;
    logic [3:0]  ADR  = 4'd0;
    logic [7:0]  DATA = 8'd0;
    logic        COMPLETED = 1'b0;
    logic        TIC, RESCAN, SAMPLE_VALID, SHAKE, FRAME_ERR;
    logic [47:0] AXIS_DATA;
    logic [2:0]  SIGN, TILT_POS, TILT_NEG;

    int n_cmp = 0;
    int n_err = 0;

    mpu_axis_monitor dut (
        .MCLK        (MCLK),
        .nRST        (nRST),
        .TIC         (TIC),
        .LOAD        (LOAD),
        .ADR         (ADR),
        .DATA        (DATA),
        .COMPLETED   (COMPLETED),
        .RESCAN      (RESCAN),
        .AXIS_DATA   (AXIS_DATA),
        .SAMPLE_VALID(SAMPLE_VALID),
        .SIGN        (SIGN),
        .TILT_POS    (TILT_POS),
        .TILT_NEG    (TILT_NEG),
        .SHAKE       (SHAKE),
        .FRAME_ERR   (FRAME_ERR)
    );

    always #5 MCLK = ~MCLK;

    typedef struct packed {
        logic        rst;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [5:0]  send;
        logic        merge;
        logic        ok;
        logic [2:0]  pos;
        logic [2:0]  neg;
        logic        shake;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic rst, input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] z, input logic [5:0] send,
                                input logic merge, input logic ok, input logic [2:0] pos,
                                input logic [2:0] neg, input logic shake);
        vec_t v;
        v.rst = rst; v.x = x; v.y = y; v.z = z; v.send = send; v.merge = merge;
        v.ok = ok; v.pos = pos; v.neg = neg; v.shake = shake;
        return v;
    endfunction

    function automatic logic [7:0] byte_of(input logic [47:0] w, input int a);
        logic [15:0] word;
        word = w[(a/2)*16 +: 16];
        return (a % 2 == 0) ? word[15:8] : word[7:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wait_tic();
        int n = 0;
        while (TIC !== 1'b1 && n < 400) begin
            @(negedge MCLK);
            n++;
        end
        chk("tic_wait", {63'd0, TIC}, 64'd1);
    endtask

    task automatic wait_collect();
        int n = 0;
        while (RESCAN !== 1'b0 && n < 400) begin
            @(negedge MCLK);
            n++;
        end
        chk("rescan_release", {63'd0, RESCAN}, 64'd0);
    endtask

    task automatic send_byte(input logic [3:0] a, input logic [7:0] d);
        wait_tic();
        ADR  = a;
        DATA = d;
        LOAD = 1'b1;
        @(negedge MCLK);
        LOAD = 1'b0;
    endtask

    task automatic do_reset();
        LOAD = 1'b0;
        COMPLETED = 1'b0;
        @(negedge MCLK);
        nRST = 1'b0;
        repeat (2) @(negedge MCLK);
        nRST = 1'b1;
    endtask

    task automatic run_frame(input int idx, input vec_t v, input logic [47:0] exp_axis);
        logic [47:0] w;
        w = {v.z, v.y, v.x};
        wait_collect();
        for (int a = 0; a < 6; a++) begin
            if (v.send[a] && !(v.merge && a == 5)) send_byte(4'(a), byte_of(w, a));
        end
        wait_tic();
        COMPLETED = 1'b1;
        if (v.merge) begin
            LOAD = 1'b1;
            ADR  = ACC_Z_L;
            DATA = byte_of(w, 5);
        end
        @(negedge MCLK);
        COMPLETED = 1'b0;
        LOAD = 1'b0;
        chk($sformatf("r%0d_valid", idx), {63'd0, SAMPLE_VALID}, {63'd0, v.ok});
        chk($sformatf("r%0d_ferr", idx), {63'd0, FRAME_ERR}, {63'd0, !v.ok});
        chk($sformatf("r%0d_axis", idx), {16'd0, AXIS_DATA}, {16'd0, exp_axis});
        chk($sformatf("r%0d_sign", idx), {61'd0, SIGN},
            {61'd0, exp_axis[47], exp_axis[31], exp_axis[15]});
        @(negedge MCLK);
        chk($sformatf("r%0d_pulses_off", idx), {62'd0, SAMPLE_VALID, FRAME_ERR}, 64'd0);
        chk($sformatf("r%0d_tilt_pos", idx), {61'd0, TILT_POS}, {61'd0, v.pos});
        chk($sformatf("r%0d_tilt_neg", idx), {61'd0, TILT_NEG}, {61'd0, v.neg});
        chk($sformatf("r%0d_shake", idx), {63'd0, SHAKE}, {63'd0, v.shake});
        @(negedge MCLK);
        chk($sformatf("r%0d_rescan", idx), {62'd0, RESCAN, SHAKE}, 64'd2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] last_axis;
        logic [47:0] exp_axis;
        localparam logic [15:0] P = 16'h1388;  // +5000
        localparam logic [15:0] N = 16'hEC78;  // -5000

        // 0xF060 is exactly -4000: sign set but not beyond the strict -THRESH compare
        tbl[0]  = mk(1, 16'h1234, 16'hF060, 16'h0005, 6'h3F, 0, 1, 3'b001, 3'b000, 0);
        tbl[1]  = mk(0, 16'hAABB, 16'hCCDD, 16'hEEFF, 6'b110111, 0, 0, 3'b001, 3'b000, 0);
        tbl[2]  = mk(0, 16'h0FA1, 16'h0000, 16'h0000, 6'h3F, 0, 1, 3'b001, 3'b000, 0);
        tbl[3]  = mk(0, 16'h0E10, 16'h0000, 16'h0000, 6'h3F, 1, 1, 3'b001, 3'b000, 0);
        tbl[4]  = mk(0, 16'h0DAB, 16'h0000, 16'h0000, 6'h3F, 0, 1, 3'b000, 3'b000, 0);
        tbl[5]  = mk(0, 16'hF05F, 16'h0000, 16'h0000, 6'h3F, 0, 1, 3'b000, 3'b001, 0);
        tbl[6]  = mk(1, P, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b001, 3'b000, 0);
        tbl[7]  = mk(0, N, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b000, 3'b001, 0);
        tbl[8]  = mk(0, P, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b001, 3'b000, 0);
        tbl[9]  = mk(0, N, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b000, 3'b001, 1);
        tbl[10] = mk(0, P, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b001, 3'b000, 0);
        // Four changes spread so the 8-frame window expires before the fourth
        tbl[11] = mk(1, P, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b001, 3'b000, 0);
        tbl[12] = mk(0, P, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b001, 3'b000, 0);
        tbl[13] = mk(0, P, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b001, 3'b000, 0);
        tbl[14] = mk(0, N, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b000, 3'b001, 0);
        tbl[15] = mk(0, N, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b000, 3'b001, 0);
        tbl[16] = mk(0, N, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b000, 3'b001, 0);
        tbl[17] = mk(0, P, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b001, 3'b000, 0);
        tbl[18] = mk(0, P, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b001, 3'b000, 0);
        tbl[19] = mk(0, N, 16'h0, 16'h0, 6'h3F, 0, 1, 3'b000, 3'b001, 0);

        // TIC cadence and quiet outputs after reset release
        do_reset();
        for (int cyc = 0; cyc <= 480; cyc++) begin
            chk($sformatf("tic_c%0d", cyc), {63'd0, TIC}, {63'd0, (cyc % 160) == 159});
            if (cyc < 159) begin
                chk("idle_outputs", {48'd0, SAMPLE_VALID, SHAKE, FRAME_ERR, RESCAN, SIGN,
                                     TILT_POS, TILT_NEG, 3'd0}, 64'd0);
                chk("idle_axis", {16'd0, AXIS_DATA}, 64'd0);
            end
            @(negedge MCLK);
        end

        last_axis = '0;
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rst) begin
                do_reset();
                last_axis = '0;
            end
            exp_axis = tbl[i].ok ? {tbl[i].z, tbl[i].y, tbl[i].x} : last_axis;
            run_frame(i, tbl[i], exp_axis);
            if (tbl[i].ok) last_axis = exp_axis;
        end

        // Reset mid-frame: partially staged bytes must not survive
        do_reset();
        send_byte(ACC_X_H, 8'hFF);
        send_byte(ACC_X_L, 8'hFF);
        send_byte(ACC_Y_H, 8'hFF);
        #3 nRST = 1'b0;
        #1 chk("reset_async", {15'd0, TIC, RESCAN, SAMPLE_VALID, SHAKE, FRAME_ERR, AXIS_DATA},
               64'd0);
        @(negedge MCLK);
        nRST = 1'b1;
        run_frame(100, mk(0, 16'h0, 16'h0, 16'h0, 6'b111000, 0, 0, 3'b000, 3'b000, 0),
                  48'd0);
        // This byte lands on the TIC that ends RESCAN and must be ignored
        send_byte(ACC_X_H, 8'h99);
        run_frame(101, mk(0, 16'h0, 16'h0, 16'h0, 6'b111110, 0, 0, 3'b000, 3'b000, 0),
                  48'd0);
        wait_collect();
        send_byte(4'd9, 8'h77);
        send_byte(ACC_X_H, 8'hEE);
        run_frame(102, mk(0, 16'hEC78, 16'h0001, 16'h7FFF, 6'h3F, 0, 1, 3'b100, 3'b001, 0),
                  {16'h7FFF, 16'h0001, 16'hEC78});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
